mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port data RAM between two requesters: port 0 is the CPU load/store unit and port 1 is the UART program loader.
- Sits in mother_board between those requesters and the RAM.
- Accepts one request at a time, arbitrates round-robin, issues a single RAM access, waits a fixed RAM latency, then returns read data or a write acknowledge to the owning requester.

Parameters:
- ADDR_W, 16, word-address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles from the mem_en cycle to mem_rdata valid; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- m0_req  in  1  port 0 request; held with its fields until m0_gnt.
- m0_we  in  1  port 0 write enable (1 = store, 0 = load).
- m0_addr  in  ADDR_W  port 0 address.
- m0_wdata  in  DATA_W  port 0 store data.
- m0_gnt  out  1  port 0 request accepted this cycle.
- m0_rvalid  out  1  port 0 completion pulse.
- m0_rdata  out  DATA_W  port 0 load data; valid with m0_rvalid.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as port 0, for port 1.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE, last = 1 (port 0 wins the first tie), wait counter = 0.
  - All outputs 0, including rdata.
- Reset mid-operation: the transaction is discarded, no rvalid is issued and mem_en drops immediately. The requester reissues after reset.
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If only one req is high, that port wins.
  - If both are high, the port != last wins.
  - The winner's mX_gnt is driven combinationally high in this cycle. It is the only Mealy output.
  - At the clock edge, latch owner, we, addr and wdata; set last = owner; go to ISSUE.
  - If neither req is high, stay in IDLE.
- ISSUE (1 cycle): mem_en = 1, with mem_we, mem_addr and mem_wdata taken from the latches. Load counter = MEM_LAT-1; go to WAIT.
- WAIT:
  - mem_en = 0 and the counter decrements.
  - When counter == 0, capture mem_rdata at the edge (write: capture 0) and go to RESP.
  - With MEM_LAT = 1, WAIT lasts exactly 1 cycle.
- RESP (1 cycle):
  - owner's rvalid = 1 and rdata = captured value; go to IDLE.
  - The non-owner's rvalid stays 0.
  - rdata outputs hold their last value after RESP; only rvalid qualifies them.
- Latency: gnt at cycle G, mem_en at G+1, rvalid at G+MEM_LAT+2.
  - The next gnt is no earlier than G+MEM_LAT+3.
  - Throughput is one access per MEM_LAT+3 cycles.
- Gnt rules:
  - No gnt outside IDLE; requests raised during a transaction wait.
  - gnt is never asserted to both ports in the same cycle.
  - Requester must deassert req in the cycle after gnt, or it is treated as a new request.
- Same-address ordering: accesses complete strictly in grant order, so a store granted before a load is visible to that load.
- Alternation: under continuous requests from both ports, grants alternate 0,1,0,1. A single port requesting alone is granted back to back.
- All mem_* outputs are registered and are 0 when not in ISSUE.

Test Plan:
- Single store then load on port 0 (MEM_LAT = 1):
  - Stimulus: store addr 3, data 4, then load addr 3.
  - Required: m0_rvalid at G+3 for each access; load returns m0_rdata = 4.
  - Required: m1_rvalid stays 0 throughout.
- Simultaneous requests from reset:
  - Stimulus: m0 loads addr 3, m1 loads addr 4, both raised in the same cycle.
  - Required: m0_gnt first, m1_gnt exactly 4 cycles later.
  - Required: rdata equals the RAM contents, 2 and 1 respectively.
- Fairness:
  - Stimulus: both reqs held high for 8 grants.
  - Required: grant sequence 0,1,0,1,0,1,0,1; busy low for exactly one cycle between transactions.
- Write-after-write:
  - Stimulus: m0 stores 4 to addr 3, then m1 stores 2 to addr 3, then m0 loads addr 3.
  - Required: load returns 2.
- Latency sweep: with MEM_LAT = 3, a load is granted at cycle G -> mem_en at G+1, m0_rvalid at G+5.
- Reset mid-operation:
  - Stimulus: assert reset during WAIT.
  - Required: all outputs 0 immediately; no rvalid after release.
  - Required: the first tie after release is granted to port 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between the CPU
// load/store unit (port 0) and the UART program loader (port 1).
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        o_dbg_state
);

  // Handshake: a requester holds req and its fields until gnt; gnt is a
  // same-cycle accept (only in IDLE) and req must drop the following cycle or
  // it counts as a new request. rvalid is a one-cycle completion pulse with no
  // backpressure; rdata holds its value afterwards.

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              r_owner;
  logic              r_last;
  logic              r_we;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (reset) begin
          if (m0_req && (!m1_req || r_last)) w_gnt0 = 1'b1;
          else if (m1_req)                   w_gnt1 = 1'b1;
        end
        if (w_gnt0 || w_gnt1) w_next = ISSUE;
      end
      ISSUE:   w_next = WAIT;
      WAIT:    if (r_cnt == '0) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_we        <= 1'b0;
      r_cnt       <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
    end else begin
      r_state     <= w_next;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_owner     <= w_gnt1;
            r_last      <= w_gnt1;
            r_we        <= w_gnt1 ? m1_we : m0_we;
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_gnt1 ? m1_we : m0_we;
            r_mem_addr  <= w_gnt1 ? m1_addr : m0_addr;
            r_mem_wdata <= w_gnt1 ? m1_wdata : m0_wdata;
          end
        end
        ISSUE: r_cnt <= CNT_INIT;
        WAIT: begin
          if (r_cnt == '0) begin
            // Writes complete with zero data so rdata never leaks stale loads.
            if (r_owner) begin
              r_rvalid1 <= 1'b1;
              r_rdata1  <= r_we ? '0 : mem_rdata;
            end else begin
              r_rvalid0 <= 1'b1;
              r_rdata0  <= r_we ? '0 : mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign m0_gnt      = w_gnt0;
  assign m1_gnt      = w_gnt1;
  assign m0_rvalid   = r_rvalid0;
  assign m1_rvalid   = r_rvalid1;
  assign m0_rdata    = r_rdata0;
  assign m1_rdata    = r_rdata1;
  assign mem_en      = r_mem_en;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign busy        = (r_state != IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-timeline reference model checked every
// cycle, directed scenarios with literal expectations, and a MEM_LAT=3 instance.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int LAT = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;

  // ---------------- DUT A (MEM_LAT = 1) ----------------
  logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    dbg_state;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .o_dbg_state(dbg_state)
  );

  // ---------------- DUT B (MEM_LAT = 3) ----------------
  logic          b_m0_req = 1'b0, b_m1_req = 1'b0;
  logic [AW-1:0] b_m0_addr = '0;
  logic          b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid;
  logic [DW-1:0] b_m0_rdata, b_m1_rdata;
  logic          b_mem_en, b_mem_we, b_busy;
  logic [AW-1:0] b_mem_addr;
  logic [DW-1:0] b_mem_wdata, b_mem_rdata;
  logic [1:0]    b_dbg_state;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) u_dut_b (
    .clk(clk), .reset(reset),
    .m0_req(b_m0_req), .m0_we(1'b0), .m0_addr(b_m0_addr), .m0_wdata('0),
    .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_req(b_m1_req), .m1_we(1'b0), .m1_addr('0), .m1_wdata('0),
    .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy), .o_dbg_state(b_dbg_state)
  );

  // ---------------- RAM models (contents reload while reset is low) ----------------
  logic [DW-1:0] ram_a [16];
  logic [DW-1:0] ram_b [16];
  logic [DW-1:0] a_rd = '0, b_p0 = '0, b_p1 = '0, b_p2 = '0;

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) ram_a[i] <= DW'(5 - i);
    end else if (mem_en) begin
      if (mem_we) ram_a[mem_addr[3:0]] <= mem_wdata;
      a_rd <= ram_a[mem_addr[3:0]];
    end
  end
  assign mem_rdata = a_rd;

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) ram_b[i] <= DW'(5 - i);
    end else if (b_mem_en) begin
      b_p0 <= ram_b[b_mem_addr[3:0]];
    end
    b_p1 <= b_p0;
    b_p2 <= b_p1;
  end
  assign b_mem_rdata = b_p2;

  // ---------------- check helpers ----------------
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, DW'(act), DW'(exp));
  endtask

  // ---------------- reference model: timeline since grant ----------------
  int            mt = -1;
  logic          mlast = 1'b1, mown = 1'b0, mwe = 1'b0;
  logic [AW-1:0] maddr = '0;
  logic [DW-1:0] mwd = '0, mexp = '0, mrd0 = '0, mrd1 = '0;
  logic [DW-1:0] gold [16];

  always @(negedge clk) begin
    logic e_g0, e_g1, e_rv0, e_rv1, e_en, e_we;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d;
    e_g0 = 1'b0; e_g1 = 1'b0; e_rv0 = 1'b0; e_rv1 = 1'b0; e_en = 1'b0; e_we = 1'b0;
    e_a = '0; e_d = '0;
    if (!reset) begin
      mt = -1; mlast = 1'b1; mrd0 = '0; mrd1 = '0;
      for (int i = 0; i < 16; i++) gold[i] = DW'(5 - i);
    end else if (mt < 0) begin
      if (m0_req && (!m1_req || mlast)) e_g0 = 1'b1;
      else if (m1_req) e_g1 = 1'b1;
    end else if (mt == 1) begin
      e_en = 1'b1; e_we = mwe; e_a = maddr; e_d = mwd;
    end else if (mt == LAT + 2) begin
      if (mown) begin e_rv1 = 1'b1; mrd1 = mexp; end
      else begin e_rv0 = 1'b1; mrd0 = mexp; end
    end
    chk1("m0_gnt", m0_gnt, e_g0);
    chk1("m1_gnt", m1_gnt, e_g1);
    chk1("m0_rvalid", m0_rvalid, e_rv0);
    chk1("m1_rvalid", m1_rvalid, e_rv1);
    chk("m0_rdata", m0_rdata, mrd0);
    chk("m1_rdata", m1_rdata, mrd1);
    chk1("mem_en", mem_en, e_en);
    chk1("mem_we", mem_we, e_we);
    chk("mem_addr", DW'(mem_addr), DW'(e_a));
    chk("mem_wdata", mem_wdata, e_d);
    chk1("busy", busy, reset && (mt >= 0));
    if (reset) begin
      if (mt < 0) begin
        if (e_g0 || e_g1) begin
          mown = e_g1; mlast = e_g1;
          mwe = e_g1 ? m1_we : m0_we;
          maddr = e_g1 ? m1_addr : m0_addr;
          mwd = e_g1 ? m1_wdata : m0_wdata;
          if (mwe) begin gold[maddr[3:0]] = mwd; mexp = '0; end
          else mexp = gold[maddr[3:0]];
          mt = 1;
        end
      end else if (mt == LAT + 2) mt = -1;
      else mt++;
    end
  end

  // ---------------- grant / idle monitor ----------------
  int gport_q[$];
  int gcyc_q[$];
  int lo_q[$];
  always @(negedge clk) begin
    if (m0_gnt) begin gport_q.push_back(0); gcyc_q.push_back(cyc); end
    if (m1_gnt) begin gport_q.push_back(1); gcyc_q.push_back(cyc); end
    if (reset && !busy) lo_q.push_back(cyc);
  end

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic do_req(input int p, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int g);
    int n = 0;
    bit got = 0;
    g = -1;
    if (p == 0) begin m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d; end
    else begin m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d; end
    while (!got && n < 200) begin
      @(negedge clk);
      if ((p == 0 && m0_gnt) || (p == 1 && m1_gnt)) begin got = 1; g = cyc; end
      n++;
    end
    chk1("gnt_seen", got, 1'b1);
    sync();
    if (p == 0) begin m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; end
    else begin m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; end
  endtask

  task automatic wait_rv(input int p, output int rc, output logic [DW-1:0] rd);
    int n = 0;
    bit got = 0;
    rc = -1; rd = '0;
    while (!got && n < 50) begin
      @(negedge clk);
      if ((p == 0) ? m0_rvalid : m1_rvalid) begin
        got = 1; rc = cyc; rd = (p == 0) ? m0_rdata : m1_rdata;
      end
      n++;
    end
    chk1("rvalid_seen", got, 1'b1);
  endtask

  task automatic rand_port(input int p);
    int g, k;
    repeat (25) begin
      k = $urandom_range(0, 3);
      if (k > 0) begin repeat (k) @(posedge clk); #1; end
      do_req(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom, g);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  int g0, g1, r0, r1, gb, eb, rb, cnt;
  logic [DW-1:0] d0, d1, rdb;

  initial begin
    repeat (3) @(posedge clk); #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk("rst_m0_rdata", m0_rdata, '0);
    chk("rst_m1_rdata", m1_rdata, '0);
    reset = 1'b1;
    sync();

    // simultaneous loads from reset: port 0 first, port 1 four cycles later
    fork
      begin do_req(0, 1'b0, 16'd3, '0, g0); wait_rv(0, r0, d0); end
      begin do_req(1, 1'b0, 16'd4, '0, g1); wait_rv(1, r1, d1); end
    join
    chk("sim_gnt_gap", g1 - g0, 32'd4);
    chk("sim_rd0", d0, 32'd2);
    chk("sim_rd1", d1, 32'd1);
    sync();

    // store then load on port 0
    do_req(0, 1'b1, 16'd3, 32'd4, g0); wait_rv(0, r0, d0);
    chk("st_rv_lat", r0 - g0, 32'd3);
    chk("st_ack_data", d0, 32'd0);
    sync();
    do_req(0, 1'b0, 16'd3, '0, g0); wait_rv(0, r0, d0);
    chk("ld_rv_lat", r0 - g0, 32'd3);
    chk("ld_data", d0, 32'd4);
    sync();

    // write after write, then load
    do_req(0, 1'b1, 16'd3, 32'd4, g0); wait_rv(0, r0, d0); sync();
    do_req(1, 1'b1, 16'd3, 32'd2, g1); wait_rv(1, r1, d1); sync();
    do_req(0, 1'b0, 16'd3, '0, g0); wait_rv(0, r0, d0);
    chk("waw_data", d0, 32'd2);
    sync();

    // fairness under continuous requests, starting from a fresh reset
    reset = 1'b0; repeat (2) @(posedge clk); #1; reset = 1'b1;
    sync();
    gport_q.delete(); gcyc_q.delete(); lo_q.delete();
    fork
      begin repeat (4) do_req(0, 1'b0, 16'd1, '0, g0); end
      begin repeat (4) do_req(1, 1'b0, 16'd2, '0, g1); end
    join
    repeat (6) @(posedge clk); #1;
    chk("fair_count", gport_q.size(), 32'd8);
    if (gport_q.size() == 8) begin
      cnt = 0;
      for (int i = 0; i < 8; i++) chk($sformatf("fair_port%0d", i), gport_q[i], i % 2);
      for (int i = 1; i < 8; i++) chk($sformatf("fair_gap%0d", i), gcyc_q[i] - gcyc_q[i-1], 32'd4);
      foreach (lo_q[i]) if (lo_q[i] > gcyc_q[0] && lo_q[i] <= gcyc_q[7]) cnt++;
      chk("fair_busy_low", cnt, 32'd7);
    end

    // randomized traffic from both ports
    fork
      rand_port(0);
      rand_port(1);
    join
    repeat (8) @(posedge clk); #1;

    // reset during WAIT
    do_req(0, 1'b0, 16'd5, '0, g0);
    @(posedge clk); #2;
    reset = 1'b0; #1;
    chk1("midrst_mem_en", mem_en, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_m0_rvalid", m0_rvalid, 1'b0);
    chk("midrst_m0_rdata", m0_rdata, '0);
    chk("midrst_m1_rdata", m1_rdata, '0);
    chk("midrst_state", DW'(dbg_state), '0);
    @(posedge clk); #1; reset = 1'b1;
    cnt = 0;
    repeat (8) begin @(negedge clk); if (m0_rvalid || m1_rvalid) cnt++; end
    chk("post_rst_no_rv", cnt, 32'd0);
    sync();
    gport_q.delete();
    fork
      do_req(0, 1'b0, 16'd6, '0, g0);
      do_req(1, 1'b0, 16'd7, '0, g1);
    join
    chk("post_rst_tie_cnt", gport_q.size(), 32'd2);
    if (gport_q.size() == 2) chk("post_rst_tie_first", gport_q[0], 32'd0);
    repeat (6) @(posedge clk); #1;

    // reset during ISSUE drops mem_en at once
    do_req(0, 1'b0, 16'd2, '0, g0);
    #1;
    chk1("issue_mem_en_pre", mem_en, 1'b1);
    reset = 1'b0; #1;
    chk1("issue_rst_mem_en", mem_en, 1'b0);
    @(posedge clk); #1; reset = 1'b1;
    sync();

    // latency sweep on the MEM_LAT = 3 instance
    b_m0_addr = 16'd6; b_m0_req = 1'b1;
    gb = -1; eb = -1; rb = -1; rdb = '0;
    for (int n = 0; n < 20 && gb < 0; n++) begin @(negedge clk); if (b_m0_gnt) gb = cyc; end
    sync(); b_m0_req = 1'b0;
    for (int n = 0; n < 20 && rb < 0; n++) begin
      @(negedge clk);
      if (b_mem_en && eb < 0) eb = cyc;
      if (b_m0_rvalid) begin rb = cyc; rdb = b_m0_rdata; end
    end
    chk("lat3_mem_en", eb - gb, 32'd1);
    chk("lat3_rvalid", rb - gb, 32'd5);
    chk("lat3_rdata", rdb, 32'hFFFF_FFFF);
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
